rr_packet_arbiter: RTL
======================

// Module: rr_packet_arbiter
// PURPOSE
//  Round-robin arbiter that shares one downstream valid/ready stream among N requesters.
//  Grants are packet-atomic: once a requester wins, it keeps the grant until its beat
//  with in_last=1 is accepted.
//  Output goes through an internal 2-entry buffer, so there is no combinational
//  out_ready->in_ready path and throughput is 1 beat/cycle.
//  Sits in front of shared match/encode resources that several lanes feed.
// PARAMETERS
//  N    4   number of requesters (>=2)
//  W    8   payload width in bits
//  SW   $clog2(N)  source-index width (localparam, not overridable)
// PORTS
//  clk            in   1      clock, all logic rising-edge
//  rst            in   1      asynchronous, active-high reset
//  in_valid       in   N      per-requester valid
//  in_ready       out  N      per-requester ready (one-hot or zero)
//  in_payload     in   N*W    requester i payload at [i*W +: W]
//  in_last        in   N      requester i end-of-packet marker
//  out_valid      out  1      buffered beat available
//  out_ready      in   1      downstream accepts
//  out_payload    out  W      head beat payload
//  out_last       out  1      head beat end-of-packet
//  out_src        out  SW     index of requester that produced head beat
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - state=IDLE, rr_ptr=0, owner=0, buffer count=0
//   - out_valid=0; out_payload, out_last and out_src read 0
//   - in_ready=0 while rst is high
//  space = (count<2), from registers only.
//   - in_ready[i] = space && (i==grant_idx) && grant_active
//  States:
//   - IDLE: grant_idx = first i with in_valid[i]=1, scanning rr_ptr, rr_ptr+1, ...
//     N-1, 0, ... (mod N); grant_active = |in_valid.
//   - IDLE, on accept (in_valid&in_ready) from i:
//     - rr_ptr <= (i+1) mod N
//     - if in_last[i]=0: owner<=i, go to LOCKED
//     - if in_last[i]=1: stay in IDLE (single-beat packet)
//   - LOCKED: grant_idx=owner, grant_active=1.
//     - Other requesters see in_ready=0 regardless of their valid.
//     - Owner dropping in_valid mid-packet: lock holds; bubbles are allowed.
//     - On an accepted beat with in_last[owner]=1: go to IDLE; rr_ptr is unchanged
//       (already owner+1).
//  Accepted beats push {payload,last,src} into the 2-entry FIFO.
//   - Latency: accept in cycle t -> out_valid=1 in cycle t+1.
//   - Pop when out_valid&&out_ready.
//   - Push and pop in the same cycle: count is unchanged, order is preserved.
//   - count==2: no push (space=0), pop still allowed.
//   - count==0 and push: head is visible the next cycle; no same-cycle bypass.
//   - out_payload, out_last and out_src are stable while out_valid&&!out_ready.
//  Fairness: after a packet from i completes, i has the lowest priority. No requester
//  waits more than N-1 packets.
//  Reset asserted mid-packet: lock and buffer are discarded, and all outputs return
//  to reset values on the next clk-independent evaluation.
// STRUCTURE
//  Shared package (beezip_stream_pkg): state enum {IDLE, LOCKED}, and the beat struct
//  {payload[W], last, src[SW]} when SV is used; plain localparams otherwise.
//  Sub-module arb_out_fifo2: 2-entry FIFO, width W+1+SW, async active-high reset,
//  valid/ready on both sides, exposes a registered "space" output.
//  Top level holds the rr pointer, the priority scan (a rotate, find-first, un-rotate
//  loop), and the IDLE/LOCKED FSM.
// TESTING
//  1. Reset: hold rst=1 with in_valid=4'b1111 -> in_ready=0 and out_valid=0.
//     Release -> the first grant goes to req0.
//  2. Single beats: all 4 requesters hold valid with last=1, out_ready=1 ->
//     out_src sequence is 0,1,2,3,0,... with one beat per cycle after 1 cycle latency.
//  3. Packet lock: req1 sends a 3-beat packet (payloads 0x11,0x12,0x13, last on
//     0x13) while req2 is valid -> req2 is granted only after 0x13 is accepted;
//     out_src = 1,1,1,2.
//  4. Backpressure: out_ready=0 with req0 streaming -> exactly 2 beats are
//     accepted and in_ready[0] drops. Raise out_ready -> the beats drain in order
//     and in_ready recovers the following cycle.
//  5. Bubble in lock: req3 drops valid for 2 cycles mid-packet while req0 is valid ->
//     in_ready[0] stays 0 and no req0 beat appears until req3's last beat.
//  6. Reset mid-packet with count==2 -> out_valid=0 immediately and state is IDLE.
//     After release the arbiter resumes at rr_ptr=0 and no stale beats are emitted.
//  Scoreboard on every run: per-source order preserved, packets never interleaved,
//  no beat lost or duplicated.

Source files
------------

// File: rtl/beezip_stream_pkg.sv
// Shared types for the packet arbiter and its output buffer.
package beezip_stream_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  localparam int ARB_FIFO_DEPTH = 2;

endpackage

// File: rtl/arb_out_fifo2.sv
// Two-entry output buffer; "space" comes straight from the occupancy register so the
// upstream ready never depends on out_ready in the same cycle.
module arb_out_fifo2
  import beezip_stream_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          space,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data
);

  logic [DW-1:0] mem_q [2];
  logic          wr_ptr_q;
  logic          rd_ptr_q;
  logic [1:0]    count_q, count_d;
  logic          push;
  logic          pop;

  assign space     = (count_q != 2'(ARB_FIFO_DEPTH));
  assign out_valid = (count_q != 2'd0);
  assign out_data  = mem_q[rd_ptr_q];
  assign push      = in_valid && space;
  assign pop       = out_valid && out_ready;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Storage is cleared too, so the head reads zero straight out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= in_data;
        wr_ptr_q        <= !wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= !rd_ptr_q;
      end
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/rr_packet_arbiter.sv
// Packet-atomic round-robin arbiter: N valid/ready requesters share one buffered
// output stream; a winner keeps the grant until its last beat is accepted.
module rr_packet_arbiter
  import beezip_stream_pkg::*;
#(
  parameter  int N  = 4,
  parameter  int W  = 8,
  localparam int SW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   in_valid,
  output logic [N-1:0]   in_ready,
  input  logic [N*W-1:0] in_payload,
  input  logic [N-1:0]   in_last,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   out_payload,
  output logic           out_last,
  output logic [SW-1:0]  out_src
);

  typedef struct packed {
    logic [W-1:0]  payload;
    logic          last;
    logic [SW-1:0] src;
  } beat_t;

  arb_state_e    state_q, state_d;
  logic [SW-1:0] rr_ptr_q, rr_ptr_d;
  logic [SW-1:0] owner_q, owner_d;
  logic [N-1:0]  rot_valid;
  logic [SW-1:0] first_off;
  logic [SW-1:0] scan_idx;
  logic [SW-1:0] grant_idx;
  logic          grant_active;
  logic          space;
  logic          push;
  logic [W-1:0]  pay_arr [N];
  beat_t         push_beat;
  beat_t         head_beat;

  // Index arithmetic modulo N; both operands are below N so one wrap suffices.
  function automatic logic [SW-1:0] wrap_add(input logic [SW-1:0] base, input int unsigned off);
    int unsigned sum;
    sum = 32'(base) + off;
    if (sum >= unsigned'(N)) sum = sum - unsigned'(N);
    return SW'(sum);
  endfunction

  for (genvar gi = 0; gi < N; gi++) begin : g_pay
    assign pay_arr[gi] = in_payload[gi*W +: W];
  end

  // Rotate so rr_ptr sits at offset 0, find the lowest set offset, rotate back.
  always_comb begin
    rot_valid = '0;
    for (int k = 0; k < N; k++) begin
      rot_valid[k] = in_valid[wrap_add(rr_ptr_q, unsigned'(k))];
    end
  end

  always_comb begin
    first_off = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot_valid[k]) first_off = SW'(k);
    end
  end

  assign scan_idx = wrap_add(rr_ptr_q, 32'(first_off));

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    owner_d      = owner_q;
    grant_idx    = scan_idx;
    grant_active = |in_valid;
    if (state_q == LOCKED) begin
      grant_idx    = owner_q;
      grant_active = 1'b1;
    end
    push = grant_active && space && in_valid[grant_idx] && !rst;
    if (push) begin
      case (state_q)
        IDLE: begin
          rr_ptr_d = wrap_add(grant_idx, 32'd1);
          if (!in_last[grant_idx]) begin
            owner_d = grant_idx;
            state_d = LOCKED;
          end
        end
        LOCKED: begin
          if (in_last[owner_q]) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready = '0;
    if (grant_active && space && !rst) in_ready[grant_idx] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
    end
  end

  assign push_beat = '{payload: pay_arr[grant_idx], last: in_last[grant_idx], src: grant_idx};

  arb_out_fifo2 #(
    .DW($bits(beat_t))
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .in_valid (push),
    .space    (space),
    .in_data  (push_beat),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (head_beat)
  );

  assign out_payload = head_beat.payload;
  assign out_last    = head_beat.last;
  assign out_src     = head_beat.src;

endmodule
